// File: rtl/dso_cmd_pkg.sv
// Shared types and constants for the DSO host command path.
// Covers the RX/TX state encodings, the opcode map and the ack bytes.
package dso_cmd_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CMD_W  = 3 * BYTE_W;

   typedef enum logic [1:0] {
      RX_B1 = 2'd0,
      RX_B2 = 2'd1,
      RX_B3 = 2'd2
   } rx_state_t;

   typedef enum logic {
      T_IDLE = 1'b0,
      T_WAIT = 1'b1
   } tx_state_t;

   // Host opcodes; the receiver never decodes them
   localparam logic [BYTE_W-1:0] DUMP_CH  = 8'h01;
   localparam logic [BYTE_W-1:0] CFG_GAIN = 8'h02;
   localparam logic [BYTE_W-1:0] TRIG_LVL = 8'h03;
   localparam logic [BYTE_W-1:0] TRIG_POS = 8'h04;
   localparam logic [BYTE_W-1:0] SET_DEC  = 8'h05;
   localparam logic [BYTE_W-1:0] TRIG_CFG = 8'h06;
   localparam logic [BYTE_W-1:0] TRIG_RD  = 8'h07;
   localparam logic [BYTE_W-1:0] EEP_WRT  = 8'h08;
   localparam logic [BYTE_W-1:0] EEP_RD   = 8'h09;

   localparam logic [BYTE_W-1:0] POS_ACK  = 8'hA5;
   localparam logic [BYTE_W-1:0] NEG_ACK  = 8'hEE;

endpackage

// File: rtl/host_cmd_rcvr.sv
// Host command endpoint: assembles 3-byte commands from the UART with an
// inter-byte timeout, and sends single response bytes back to the host.
import dso_cmd_pkg::*;

module host_cmd_rcvr #(
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_rdy,
   output logic              clr_rx_rdy,
   output logic [CMD_W-1:0]  cmd,
   output logic              cmd_rdy,
   input  logic              clr_cmd_rdy,
   output logic              cmd_ovr,
   output logic              frm_to,
   input  logic [BYTE_W-1:0] resp_data,
   input  logic              send_resp,
   output logic              resp_busy,
   output logic              resp_sent,
   output logic [BYTE_W-1:0] tx_data,
   output logic              trmt,
   input  logic              tx_done
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   rx_state_t         r_rx_state, w_rx_state_nxt;
   logic [CNT_W-1:0]  r_to_cnt, w_to_cnt_nxt;
   logic [BYTE_W-1:0] r_sh1, w_sh1_nxt;
   logic [BYTE_W-1:0] r_sh2, w_sh2_nxt;
   logic [CMD_W-1:0]  r_cmd, w_cmd_nxt;
   logic              r_cmd_rdy, w_cmd_rdy_nxt;
   logic              r_cmd_ovr, w_cmd_ovr_nxt;
   logic              r_frm_to, w_frm_to_nxt;
   logic              r_clr_rx_rdy, w_clr_rx_rdy_nxt;

   tx_state_t         r_tx_state, w_tx_state_nxt;
   logic [BYTE_W-1:0] r_tx_data, w_tx_data_nxt;
   logic              r_trmt, w_trmt_nxt;
   logic              r_resp_busy, w_resp_busy_nxt;
   logic              r_resp_sent, w_resp_sent_nxt;

   logic              w_accept;
   logic              w_timeout;

   // The pending clr pulse masks rx_rdy so one byte is never taken twice
   assign w_accept  = rx_rdy & ~r_clr_rx_rdy;
   assign w_timeout = (r_rx_state != RX_B1) && (r_to_cnt == TO_LAST) && !w_accept;

   // RX next-state: byte capture, command assembly, overrun and timeout
   always_comb begin
      w_rx_state_nxt   = r_rx_state;
      w_to_cnt_nxt     = r_to_cnt;
      w_sh1_nxt        = r_sh1;
      w_sh2_nxt        = r_sh2;
      w_cmd_nxt        = r_cmd;
      w_cmd_rdy_nxt    = r_cmd_rdy;
      w_cmd_ovr_nxt    = r_cmd_ovr;
      w_frm_to_nxt     = 1'b0;
      w_clr_rx_rdy_nxt = w_accept;

      if (clr_cmd_rdy) begin
         w_cmd_rdy_nxt = 1'b0;
         w_cmd_ovr_nxt = 1'b0;
      end

      if (w_accept) begin
         w_to_cnt_nxt = '0;
         case (r_rx_state)
            RX_B1: begin
               w_sh1_nxt      = rx_data;
               w_rx_state_nxt = RX_B2;
            end
            RX_B2: begin
               w_sh2_nxt      = rx_data;
               w_rx_state_nxt = RX_B3;
            end
            RX_B3: begin
               w_cmd_nxt      = {r_sh1, r_sh2, rx_data};
               w_cmd_rdy_nxt  = 1'b1;
               w_cmd_ovr_nxt  = w_cmd_ovr_nxt | (r_cmd_rdy & ~clr_cmd_rdy);
               w_rx_state_nxt = RX_B1;
            end
            default: w_rx_state_nxt = RX_B1;
         endcase
      end else if (w_timeout) begin
         w_rx_state_nxt = RX_B1;
         w_to_cnt_nxt   = '0;
         w_sh1_nxt      = '0;
         w_sh2_nxt      = '0;
         w_frm_to_nxt   = 1'b1;
      end else if (r_rx_state != RX_B1) begin
         w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state   <= RX_B1;
         r_to_cnt     <= '0;
         r_sh1        <= '0;
         r_sh2        <= '0;
         r_cmd        <= '0;
         r_cmd_rdy    <= 1'b0;
         r_cmd_ovr    <= 1'b0;
         r_frm_to     <= 1'b0;
         r_clr_rx_rdy <= 1'b0;
      end else begin
         r_rx_state   <= w_rx_state_nxt;
         r_to_cnt     <= w_to_cnt_nxt;
         r_sh1        <= w_sh1_nxt;
         r_sh2        <= w_sh2_nxt;
         r_cmd        <= w_cmd_nxt;
         r_cmd_rdy    <= w_cmd_rdy_nxt;
         r_cmd_ovr    <= w_cmd_ovr_nxt;
         r_frm_to     <= w_frm_to_nxt;
         r_clr_rx_rdy <= w_clr_rx_rdy_nxt;
      end
   end

   // TX next-state; tx_done in the trmt cycle is stale from the previous byte
   always_comb begin
      w_tx_state_nxt  = r_tx_state;
      w_tx_data_nxt   = r_tx_data;
      w_trmt_nxt      = 1'b0;
      w_resp_sent_nxt = 1'b0;

      case (r_tx_state)
         T_IDLE: begin
            if (send_resp) begin
               w_tx_data_nxt  = resp_data;
               w_trmt_nxt     = 1'b1;
               w_tx_state_nxt = T_WAIT;
            end
         end
         T_WAIT: begin
            if (tx_done && !r_trmt) begin
               w_resp_sent_nxt = 1'b1;
               w_tx_state_nxt  = T_IDLE;
            end
         end
         default: w_tx_state_nxt = T_IDLE;
      endcase

      w_resp_busy_nxt = (w_tx_state_nxt == T_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state  <= T_IDLE;
         r_tx_data   <= '0;
         r_trmt      <= 1'b0;
         r_resp_busy <= 1'b0;
         r_resp_sent <= 1'b0;
      end else begin
         r_tx_state  <= w_tx_state_nxt;
         r_tx_data   <= w_tx_data_nxt;
         r_trmt      <= w_trmt_nxt;
         r_resp_busy <= w_resp_busy_nxt;
         r_resp_sent <= w_resp_sent_nxt;
      end
   end

   assign clr_rx_rdy = r_clr_rx_rdy;
   assign cmd        = r_cmd;
   assign cmd_rdy    = r_cmd_rdy;
   assign cmd_ovr    = r_cmd_ovr;
   assign frm_to     = r_frm_to;
   assign tx_data    = r_tx_data;
   assign trmt       = r_trmt;
   assign resp_busy  = r_resp_busy;
   assign resp_sent  = r_resp_sent;

endmodule

// File: tb/tb_host_cmd_rcvr.sv
// Directed bench for host_cmd_rcvr: frame assembly, timeout, overrun,
// response transmit and reset recovery, with hand-computed expectations.
module tb_host_cmd_rcvr;
   import dso_cmd_pkg::*;

   localparam int unsigned TO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        clr_rx_rdy;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        cmd_ovr;
   logic        frm_to;
   logic [7:0]  resp_data;
   logic        send_resp;
   logic        resp_busy;
   logic        resp_sent;
   logic [7:0]  tx_data;
   logic        trmt;
   logic        tx_done;

   int n_checks = 0;
   int n_errors = 0;
   int n_clr    = 0;
   int n_frm_to = 0;
   int n_trmt   = 0;
   int n_sent   = 0;

   host_cmd_rcvr #(.TIMEOUT_CYC(TO), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .clr_rx_rdy (clr_rx_rdy),
      .cmd        (cmd),
      .cmd_rdy    (cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy),
      .cmd_ovr    (cmd_ovr),
      .frm_to     (frm_to),
      .resp_data  (resp_data),
      .send_resp  (send_resp),
      .resp_busy  (resp_busy),
      .resp_sent  (resp_sent),
      .tx_data    (tx_data),
      .trmt       (trmt),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // Pulse counters
   always @(posedge clk) begin
      if (clr_rx_rdy) n_clr    <= n_clr + 1;
      if (frm_to)     n_frm_to <= n_frm_to + 1;
      if (trmt)       n_trmt   <= n_trmt + 1;
      if (resp_sent)  n_sent   <= n_sent + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Present one byte like the UART core; returns in the cycle clr_rx_rdy is high
   task automatic send_byte(input logic [7:0] b, input bit with_clr, input int gap);
      int k;
      k = 0;
      repeat (gap) @(negedge clk);
      rx_data = b;
      rx_rdy  = 1'b1;
      if (with_clr) clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      while (!clr_rx_rdy && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("rx_ack", {31'd0, clr_rx_rdy}, 32'd1);
      rx_rdy = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input bit clr_last);
      send_byte(b1, 1'b0, 3);
      send_byte(b2, 1'b0, 3);
      send_byte(b3, clr_last, 3);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      check("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
      check("clr_ovr", {31'd0, cmd_ovr}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_clr_rx"},  {31'd0, clr_rx_rdy}, 32'd0);
      check({pfx, "_cmd"},     {8'd0, cmd},         32'd0);
      check({pfx, "_cmd_rdy"}, {31'd0, cmd_rdy},    32'd0);
      check({pfx, "_cmd_ovr"}, {31'd0, cmd_ovr},    32'd0);
      check({pfx, "_frm_to"},  {31'd0, frm_to},     32'd0);
      check({pfx, "_busy"},    {31'd0, resp_busy},  32'd0);
      check({pfx, "_sent"},    {31'd0, resp_sent},  32'd0);
      check({pfx, "_tx_data"}, {24'd0, tx_data},    32'd0);
      check({pfx, "_trmt"},    {31'd0, trmt},       32'd0);
   endtask

   initial begin
      int k;
      int clr0;
      rst         = 1'b1;
      rx_data     = 8'h00;
      rx_rdy      = 1'b0;
      clr_cmd_rdy = 1'b0;
      resp_data   = 8'h00;
      send_resp   = 1'b0;
      tx_done     = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b0;
      @(negedge clk);

      // Basic frame with sub-timeout gaps
      clr0 = n_clr;
      send_byte(EEP_WRT, 1'b0, 20);
      send_byte(8'h2A,   1'b0, 20);
      send_byte(8'hFF,   1'b0, 20);
      check("f1_cmd", {8'd0, cmd}, 32'h00082AFF);
      check("f1_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("f1_ovr", {31'd0, cmd_ovr}, 32'd0);
      @(negedge clk);
      check("f1_clr_cnt", 32'(n_clr - clr0), 32'd3);
      check("f1_no_to", 32'(n_frm_to), 32'd0);
      pulse_clr();

      // Partial frame dropped by timeout
      send_byte(CFG_GAIN, 1'b0, 3);
      send_byte(8'h1C,    1'b0, 3);
      k = 0;
      while (!frm_to && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("to_latency", 32'(k), 32'(TO));
      @(negedge clk);
      check("to_pulse_w", {31'd0, frm_to}, 32'd0);
      check("to_cmd_kept", {8'd0, cmd}, 32'h00082AFF);
      check("to_rdy_kept", {31'd0, cmd_rdy}, 32'd0);
      send_frame(TRIG_LVL, 8'hFF, 8'hAA, 1'b0);
      check("f2_cmd", {8'd0, cmd}, 32'h0003FFAA);
      check("f2_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("to_count", 32'(n_frm_to), 32'd1);
      pulse_clr();

      // Overrun and clear/completion collision
      send_frame(DUMP_CH, 8'h11, 8'h22, 1'b0);
      check("ov_a_cmd", {8'd0, cmd}, 32'h00011122);
      check("ov_a_ovr", {31'd0, cmd_ovr}, 32'd0);
      send_frame(SET_DEC, 8'h33, 8'h44, 1'b0);
      check("ov_b_cmd", {8'd0, cmd}, 32'h00053344);
      check("ov_b_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("ov_b_ovr", {31'd0, cmd_ovr}, 32'd1);
      pulse_clr();
      send_frame(TRIG_POS, 8'h77, 8'h88, 1'b0);
      send_frame(TRIG_CFG, 8'h99, 8'hAA, 1'b0);
      check("ov_d_ovr", {31'd0, cmd_ovr}, 32'd1);
      send_frame(EEP_WRT, 8'hBB, 8'hCC, 1'b1);
      check("coll_cmd", {8'd0, cmd}, 32'h0008BBCC);
      check("coll_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("coll_ovr", {31'd0, cmd_ovr}, 32'd0);

      // Response transmit; stale tx_done in trmt cycle, second request dropped
      @(negedge clk);
      resp_data = POS_ACK;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      resp_data = NEG_ACK;
      check("tx_trmt", {31'd0, trmt}, 32'd1);
      check("tx_data", {24'd0, tx_data}, 32'h000000A5);
      check("tx_busy", {31'd0, resp_busy}, 32'd1);
      @(negedge clk);
      tx_done = 1'b0;
      check("tx_stale_done", {31'd0, resp_sent}, 32'd0);
      check("tx_busy_hold", {31'd0, resp_busy}, 32'd1);
      @(negedge clk);
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      repeat (4) @(negedge clk);
      check("tx_busy_wait", {31'd0, resp_busy}, 32'd1);
      tx_done = 1'b1;
      @(negedge clk);
      check("tx_sent", {31'd0, resp_sent}, 32'd1);
      check("tx_idle", {31'd0, resp_busy}, 32'd0);
      repeat (5) @(negedge clk);
      check("tx_trmt_cnt", 32'(n_trmt), 32'd1);
      check("tx_sent_cnt", 32'(n_sent), 32'd1);
      check("tx_data_hold", {24'd0, tx_data}, 32'h000000A5);

      // Reset mid-frame and mid-transmit
      tx_done = 1'b0;
      send_byte(EEP_RD, 1'b0, 3);
      resp_data = NEG_ACK;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      check("pre_rst_busy", {31'd0, resp_busy}, 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst1");
      rst = 1'b0;
      tx_done = 1'b1;
      send_frame(TRIG_RD, 8'hBA, 8'hE0, 1'b0);
      check("f3_cmd", {8'd0, cmd}, 32'h0007BAE0);
      check("f3_rdy", {31'd0, cmd_rdy}, 32'd1);
      check("f3_ovr", {31'd0, cmd_ovr}, 32'd0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
